// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaler and period counter, per-channel
// compare and polarity, edge/centre counting, double-buffered compare and period.
module pwm_multi #(
    parameter int NCH       = 4,
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 8,
    parameter int AW        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [DIV_WIDTH-1:0] scale,
    input  logic [NCH-1:0]       polarity,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CNT_WIDTH-1:0] wr_data,
    output logic [NCH-1:0]       pwm_out,
    output logic                 period_tick,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 dir
);

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTRE = 1'b1
    } mode_e;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam logic [AW-1:0] PERIOD_ADDR = AW'(NCH);
    localparam cnt_t          CNT_ONE     = cnt_t'(1);

    mode_e mode_sel;

    logic [DIV_WIDTH-1:0] prescale_q, prescale_d;
    cnt_t                 count_q, count_d;
    logic                 dir_q, dir_d;
    cnt_t                 period_act_q, period_act_d;
    cnt_t                 period_sh_q, period_sh_d;
    cnt_t                 match_act_q [NCH];
    cnt_t                 match_act_d [NCH];
    cnt_t                 match_sh_q  [NCH];
    cnt_t                 match_sh_d  [NCH];
    logic [NCH-1:0]       pwm_q, pwm_d;
    logic                 period_tick_q, period_tick_d;

    logic                 tick;
    cnt_t                 cnt_step;
    logic                 dir_step;
    logic                 wrap;

    assign mode_sel = mode_e'(mode);

    // Counter successor for the current mode/direction; only applied on a tick.
    always_comb begin : counter_next
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        cnt_step = count_q;
        dir_step = 1'b0;
        wrap     = 1'b0;
        if (mode_sel == MODE_EDGE) begin
            if (count_q >= period_act_q) begin
                cnt_step = '0;
                wrap     = 1'b1;
            end else begin
                cnt_step = count_q + CNT_ONE;
            end
        end else if (!dir_q) begin
            if (period_act_q == '0) begin
                cnt_step = '0;
                wrap     = 1'b1;
            end else if (count_q >= period_act_q) begin
                cnt_step = period_act_q - CNT_ONE;
                dir_step = 1'b1;
            end else begin
                cnt_step = count_q + CNT_ONE;
            end
        end else begin
            if (count_q == '0) begin
                cnt_step = CNT_ONE;
                wrap     = 1'b1;
            end else begin
                cnt_step = count_q - CNT_ONE;
                dir_step = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        prescale_d    = prescale_q;
        count_d       = count_q;
        dir_d         = dir_q;
        period_act_d  = period_act_q;
        period_sh_d   = period_sh_q;
        match_act_d   = match_act_q;
        match_sh_d    = match_sh_q;
        pwm_d         = pwm_q;
        period_tick_d = 1'b0;
        tick          = 1'b0;

        if (wr_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_addr == AW'(i)) begin
                    match_sh_d[i] = wr_data;
                end
            end
            if (wr_addr == PERIOD_ADDR) begin
                period_sh_d = wr_data;
            end
        end

        if (!enable) begin
            prescale_d = '0;
            count_d    = '0;
            dir_d      = 1'b0;
            pwm_d      = polarity;
        end else begin
            tick       = (prescale_q == '0);
            prescale_d = tick ? scale : prescale_q - 1'b1;
            if (tick) begin
                for (int i = 0; i < NCH; i++) begin
                    pwm_d[i] = (count_q < match_act_q[i]) ^ polarity[i];
                end
                count_d = cnt_step;
                dir_d   = dir_step;
                // Active load uses the registered shadows, so a same-clock write waits a period.
                if (wrap) begin
                    match_act_d   = match_sh_q;
                    period_act_d  = period_sh_q;
                    period_tick_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q    <= '0;
            count_q       <= '0;
            dir_q         <= 1'b0;
            period_act_q  <= '0;
            period_sh_q   <= '0;
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
            // NOTE: shadow and active compare arrays are small flop banks, so they reset with the rest.
            for (int i = 0; i < NCH; i++) begin
                match_act_q[i] <= '0;
                match_sh_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            prescale_q    <= prescale_d;
            count_q       <= count_d;
            dir_q         <= dir_d;
            period_act_q  <= period_act_d;
            period_sh_q   <= period_sh_d;
            pwm_q         <= pwm_d;
            period_tick_q <= period_tick_d;
            match_act_q   <= match_act_d;
            match_sh_q    <= match_sh_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;
    assign count       = count_q;
    assign dir         = dir_q;

endmodule
